// File: rtl/bram_port_initiator_pkg.sv
// Shared definitions for the BRAM port initiator: data-path widths,
// the response-entry layout and small address helpers.
package bram_port_initiator_pkg;

    localparam int unsigned C_BRAM_DWIDTH = 32;
    localparam int unsigned C_BRAM_NUM_WE = 4;
    localparam int unsigned C_BRAM_RD_LAT = 1;

    // Response entry: {wr, err, data[0:31]}, 34 bits total.
    typedef struct packed {
        logic                       wr;
        logic                       err;
        logic [0:C_BRAM_DWIDTH-1]   data;
    } rsp_entry_t;

    localparam rsp_entry_t C_RSP_ENTRY_ZERO = '{wr: 1'b0, err: 1'b0, data: 32'h0000_0000};

    // True when the byte address falls inside the memory.
    function automatic logic addr_in_range(input logic [0:31] addr, input logic [0:31] limit);
        return (addr < limit);
    endfunction

    // Drop the byte-offset bits to form a word-aligned byte address.
    function automatic logic [0:31] word_align(input logic [0:31] addr);
        return {addr[0:29], 2'b00};
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// First-word-fall-through FIFO holding response entries. The head entry
// is presented combinationally from storage; an empty FIFO shows zeros.
module bram_rsp_fifo
    import bram_port_initiator_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        push_i,
    input  rsp_entry_t  push_data_i,
    input  logic        pop_i,
    output logic        valid_o,
    output rsp_entry_t  head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    rsp_entry_t         mem_q [0:DEPTH-1];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               do_push_s;
    logic               do_pop_s;

    // Pointer wrap that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign do_push_s = push_i && (cnt_q != CNT_W'(DEPTH));
    assign do_pop_s  = pop_i && (cnt_q != CNT_W'(0));

    // Next-state for pointers and fill count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage; cleared on reset so no stale entry can resurface.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= C_RSP_ENTRY_ZERO;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (cnt_q != CNT_W'(0));
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : C_RSP_ENTRY_ZERO;

endmodule

// File: rtl/bram_port_initiator.sv
// Initiator for one 32-bit BRAM port: accepts word requests, drives the
// BRAM port from registers, captures read data one cycle later and
// returns ordered responses through a small FWFT FIFO. An occupancy
// counter covering both in-flight and queued responses throttles
// request acceptance so the FIFO can never overflow.
module bram_port_initiator
    import bram_port_initiator_pkg::*;
#(
    parameter int unsigned C_MEMSIZE   = 32'h0000_4000,
    parameter int unsigned C_RSP_DEPTH = 4
) (
    input  logic                        BRAM_Clk,
    input  logic                        BRAM_Rst_N,
    input  logic                        Req_Valid,
    output logic                        Req_Ready,
    input  logic                        Req_Wr,
    input  logic [0:31]                 Req_Addr,
    input  logic [0:C_BRAM_DWIDTH-1]    Req_Data,
    input  logic [0:C_BRAM_NUM_WE-1]    Req_BE,
    output logic                        Rsp_Valid,
    input  logic                        Rsp_Ready,
    output logic                        Rsp_Wr,
    output logic                        Rsp_Err,
    output logic [0:C_BRAM_DWIDTH-1]    Rsp_Data,
    output logic                        BRAM_Clk_O,
    output logic                        BRAM_Rst,
    output logic                        BRAM_EN,
    output logic [0:C_BRAM_NUM_WE-1]    BRAM_WEN,
    output logic [0:31]                 BRAM_Addr,
    output logic [0:C_BRAM_DWIDTH-1]    BRAM_Dout,
    input  logic [0:C_BRAM_DWIDTH-1]    BRAM_Din
);

    localparam int unsigned OCC_W = $clog2(C_RSP_DEPTH + 1);

    // Occupancy
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic                       accept_s;
    logic                       rsp_hs_s;
    logic                       in_range_s;

    // Issue stage (drives the BRAM port)
    logic                       en_q, en_d;
    logic [0:C_BRAM_NUM_WE-1]   wen_q, wen_d;
    logic [0:31]                addr_q, addr_d;
    logic [0:C_BRAM_DWIDTH-1]   dout_q, dout_d;
    logic                       iss_vld_q, iss_vld_d;
    logic                       iss_wr_q, iss_wr_d;
    logic                       iss_err_q, iss_err_d;

    // Capture stage (BRAM read data valid this cycle)
    logic                       cap_vld_q, cap_vld_d;
    logic                       cap_wr_q, cap_wr_d;
    logic                       cap_err_q, cap_err_d;

    // Response FIFO
    rsp_entry_t                 push_entry_s;
    rsp_entry_t                 rsp_head_s;
    logic                       rsp_valid_s;

    // Ready is held low while reset is asserted; otherwise it depends only
    // on the registered occupancy, never on Req_Valid.
    assign Req_Ready  = BRAM_Rst_N && (occ_q < OCC_W'(C_RSP_DEPTH));
    assign accept_s   = Req_Valid && Req_Ready;
    assign rsp_hs_s   = rsp_valid_s && Rsp_Ready;
    assign in_range_s = addr_in_range(Req_Addr, 32'(C_MEMSIZE));

    // Occupancy next-state: +1 on accept, -1 on response handshake.
    always_comb begin
        occ_d = occ_q;
        case ({accept_s, rsp_hs_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // Issue-stage next-state: strobes are single-cycle, address/data hold.
    always_comb begin
        en_d      = 1'b0;
        wen_d     = 4'b0000;
        addr_d    = addr_q;
        dout_d    = dout_q;
        iss_vld_d = 1'b0;
        iss_wr_d  = 1'b0;
        iss_err_d = 1'b0;
        if (accept_s) begin
            en_d      = in_range_s;
            wen_d     = (Req_Wr && in_range_s) ? Req_BE : 4'b0000;
            addr_d    = word_align(Req_Addr);
            dout_d    = Req_Data;
            iss_vld_d = 1'b1;
            iss_wr_d  = Req_Wr;
            iss_err_d = !in_range_s;
        end else begin
            en_d      = 1'b0;
            wen_d     = 4'b0000;
            iss_vld_d = 1'b0;
        end
    end

    // Capture-stage next-state: the request tag follows the BRAM access.
    always_comb begin
        cap_vld_d = iss_vld_q;
        cap_wr_d  = iss_wr_q;
        cap_err_d = iss_err_q;
    end

    // Entry pushed into the FIFO; only in-range reads carry BRAM data.
    always_comb begin
        push_entry_s      = C_RSP_ENTRY_ZERO;
        push_entry_s.wr   = cap_wr_q;
        push_entry_s.err  = cap_err_q;
        if (!cap_wr_q && !cap_err_q) begin
            push_entry_s.data = BRAM_Din;
        end else begin
            push_entry_s.data = 32'h0000_0000;
        end
    end

    // Occupancy, issue and capture registers.
    always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
        if (!BRAM_Rst_N) begin
            occ_q     <= '0;
            en_q      <= 1'b0;
            wen_q     <= 4'b0000;
            addr_q    <= 32'h0000_0000;
            dout_q    <= 32'h0000_0000;
            iss_vld_q <= 1'b0;
            iss_wr_q  <= 1'b0;
            iss_err_q <= 1'b0;
            cap_vld_q <= 1'b0;
            cap_wr_q  <= 1'b0;
            cap_err_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            en_q      <= en_d;
            wen_q     <= wen_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            iss_vld_q <= iss_vld_d;
            iss_wr_q  <= iss_wr_d;
            iss_err_q <= iss_err_d;
            cap_vld_q <= cap_vld_d;
            cap_wr_q  <= cap_wr_d;
            cap_err_q <= cap_err_d;
        end
    end

    bram_rsp_fifo #(
        .DEPTH (C_RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (BRAM_Clk),
        .rst_ni      (BRAM_Rst_N),
        .push_i      (cap_vld_q),
        .push_data_i (push_entry_s),
        .pop_i       (rsp_hs_s),
        .valid_o     (rsp_valid_s),
        .head_o      (rsp_head_s)
    );

    assign Rsp_Valid  = rsp_valid_s;
    assign Rsp_Wr     = rsp_head_s.wr;
    assign Rsp_Err    = rsp_head_s.err;
    assign Rsp_Data   = rsp_head_s.data;

    assign BRAM_Clk_O = BRAM_Clk;
    assign BRAM_Rst   = !BRAM_Rst_N;
    assign BRAM_EN    = en_q;
    assign BRAM_WEN   = wen_q;
    assign BRAM_Addr  = addr_q;
    assign BRAM_Dout  = dout_q;

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator with a behavioural BRAM model
// (one-cycle read latency, byte write enables, read-before-write).
module tb_bram_port_initiator;

    logic        clk;
    logic        rst_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Wr;
    logic [0:31] Req_Addr;
    logic [0:31] Req_Data;
    logic [0:3]  Req_BE;
    logic        Rsp_Valid;
    logic        Rsp_Ready;
    logic        Rsp_Wr;
    logic        Rsp_Err;
    logic [0:31] Rsp_Data;
    logic        BRAM_Clk_O;
    logic        BRAM_Rst;
    logic        BRAM_EN;
    logic [0:3]  BRAM_WEN;
    logic [0:31] BRAM_Addr;
    logic [0:31] BRAM_Dout;
    logic [0:31] BRAM_Din;

    int n_checks = 0;
    int n_fail   = 0;

    bram_port_initiator #(
        .C_MEMSIZE   (32'h0000_4000),
        .C_RSP_DEPTH (4)
    ) dut (
        .BRAM_Clk   (clk),
        .BRAM_Rst_N (rst_n),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_Wr     (Req_Wr),
        .Req_Addr   (Req_Addr),
        .Req_Data   (Req_Data),
        .Req_BE     (Req_BE),
        .Rsp_Valid  (Rsp_Valid),
        .Rsp_Ready  (Rsp_Ready),
        .Rsp_Wr     (Rsp_Wr),
        .Rsp_Err    (Rsp_Err),
        .Rsp_Data   (Rsp_Data),
        .BRAM_Clk_O (BRAM_Clk_O),
        .BRAM_Rst   (BRAM_Rst),
        .BRAM_EN    (BRAM_EN),
        .BRAM_WEN   (BRAM_WEN),
        .BRAM_Addr  (BRAM_Addr),
        .BRAM_Dout  (BRAM_Dout),
        .BRAM_Din   (BRAM_Din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- BRAM model ----------------
    logic [0:31] bram_mem  [0:4095];
    logic        bram_seen [0:4095];
    logic        mem_clr;

    // Initial contents: words 64..95 hold a recognisable pattern, rest zero.
    function automatic logic [31:0] pat(input int idx);
        if (idx >= 64 && idx < 96) begin
            return 32'hA500_0000 | 32'(idx);
        end else begin
            return 32'h0000_0000;
        end
    endfunction

    // Synchronous BRAM port: read-before-write, byte 0 = bits [0:7].
    always @(posedge clk) begin
        logic [31:0] a;
        logic [0:31] cur;
        int idx;
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) bram_seen[i] <= 1'b0;
        end else if (BRAM_EN) begin
            a   = BRAM_Addr;
            idx = int'(a[13:2]);
            cur = bram_seen[idx] ? bram_mem[idx] : pat(idx);
            BRAM_Din <= cur;
            for (int b = 0; b < 4; b++) begin
                if (BRAM_WEN[b]) cur[8*b +: 8] = BRAM_Dout[8*b +: 8];
            end
            bram_mem[idx]  <= cur;
            bram_seen[idx] <= 1'b1;
        end
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- single-request helper ----------------
    // Entered just after a rising edge; leaves just after the handshake edge.
    task automatic single(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] be,
                          input logic exp_en, input logic [3:0] exp_wen,
                          input logic [31:0] exp_data, input logic exp_err);
        Req_Valid = 1'b1;
        Req_Wr    = wr;
        Req_Addr  = addr;
        Req_Data  = data;
        Req_BE    = be;
        Rsp_Ready = 1'b1;
        @(negedge clk);
        check_val({tag, ".ready"}, 32'(Req_Ready), 32'd1);
        @(posedge clk);                         // E0: accept
        #1 Req_Valid = 1'b0;
        @(negedge clk);
        check_val({tag, ".en"},   32'(BRAM_EN), 32'(exp_en));
        check_val({tag, ".wen"},  32'(BRAM_WEN), 32'(exp_wen));
        check_val({tag, ".addr"}, BRAM_Addr, addr & 32'hFFFF_FFFC);
        check_val({tag, ".dout"}, BRAM_Dout, data);
        check_val({tag, ".rv0"},  32'(Rsp_Valid), 32'd0);
        @(negedge clk);                         // after E1
        check_val({tag, ".en_off"}, 32'(BRAM_EN), 32'd0);
        check_val({tag, ".rv1"},    32'(Rsp_Valid), 32'd0);
        @(negedge clk);                         // after E2
        check_val({tag, ".rv2"},  32'(Rsp_Valid), 32'd1);
        check_val({tag, ".rwr"},  32'(Rsp_Wr), 32'(wr));
        check_val({tag, ".rerr"}, 32'(Rsp_Err), 32'(exp_err));
        check_val({tag, ".rdat"}, Rsp_Data, exp_data);
        @(posedge clk);                         // handshake
        #1;
    endtask

    // ---------------- streaming helpers ----------------
    int          idx;
    int          nreq;
    int          base_word;
    int          cyc;
    logic        last_rdy;
    logic [31:0] got[$];
    int          got_cyc[$];

    task automatic drive_req();
        if (idx < nreq) begin
            Req_Valid = 1'b1;
            Req_Wr    = 1'b0;
            Req_Addr  = 32'((base_word + idx) * 4);
            Req_Data  = 32'h0000_0000;
            Req_BE    = 4'b0000;
        end else begin
            Req_Valid = 1'b0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        last_rdy = Req_Ready;
        if (Rsp_Valid && Rsp_Ready) begin
            got.push_back(Rsp_Data);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (Req_Valid && last_rdy) idx++;
        cyc++;
        #1 drive_req();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_clr   = 1'b1;
        Req_Valid = 1'b0;
        Req_Wr    = 1'b0;
        Req_Addr  = 32'h0;
        Req_Data  = 32'h0;
        Req_BE    = 4'b0000;
        Rsp_Ready = 1'b0;
        #1;
        // Reset state
        check_val("rst.ready", 32'(Req_Ready), 32'd0);
        check_val("rst.rv",    32'(Rsp_Valid), 32'd0);
        check_val("rst.en",    32'(BRAM_EN), 32'd0);
        check_val("rst.addr",  BRAM_Addr, 32'h0);
        check_val("rst.bram_rst", 32'(BRAM_Rst), 32'd1);
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        #1 check_val("rel.ready", 32'(Req_Ready), 32'd1);
        check_val("rel.bram_rst", 32'(BRAM_Rst), 32'd0);
        @(posedge clk);
        #1;

        // Full write, read back
        single("wr10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 4'b1111, 32'h0, 1'b0);
        single("rd10", 1'b0, 32'h10, 32'h0,        4'b0000, 1'b1, 4'b0000, 32'hDEADBEEF, 1'b0);
        // Partial write (byte 0 only) over zero contents
        single("wr20", 1'b1, 32'h20, 32'h11223344, 4'b1000, 1'b1, 4'b1000, 32'h0, 1'b0);
        single("rd20", 1'b0, 32'h20, 32'h0,        4'b0000, 1'b1, 4'b0000, 32'h11000000, 1'b0);
        // Misaligned, no byte enables: aligned address, nothing written
        single("wr22", 1'b1, 32'h22, 32'hFFFFFFFF, 4'b0000, 1'b1, 4'b0000, 32'h0, 1'b0);
        single("rd20b", 1'b0, 32'h20, 32'h0,       4'b0000, 1'b1, 4'b0000, 32'h11000000, 1'b0);
        // Out of range
        single("rd4000", 1'b0, 32'h4000, 32'h0,        4'b0000, 1'b0, 4'b0000, 32'h0, 1'b1);
        single("wr4000", 1'b1, 32'h4000, 32'h12345678, 4'b1111, 1'b0, 4'b0000, 32'h0, 1'b1);
        // Last legal word
        single("rd3ffc", 1'b0, 32'h3FFF, 32'h0,        4'b0000, 1'b1, 4'b0000, 32'h0, 1'b0);

        // Backpressure: 6 requests, Rsp_Ready low
        Rsp_Ready = 1'b0;
        idx = 0; nreq = 6; base_word = 64; cyc = 0;
        got.delete(); got_cyc.delete();
        drive_req();
        repeat (8) cycle();
        check_val("bp.accepted", 32'(idx), 32'd4);
        check_val("bp.ready_lo", 32'(last_rdy), 32'd0);
        check_val("bp.no_rsp",   32'(got.size()), 32'd0);
        Rsp_Ready = 1'b1;
        cycle();
        check_val("bp.ready_still_lo", 32'(last_rdy), 32'd0);
        cycle();
        check_val("bp.ready_back", 32'(last_rdy), 32'd1);
        for (int g = 0; g < 30 && got.size() < 6; g++) cycle();
        check_val("bp.accepted_all", 32'(idx), 32'd6);
        check_val("bp.rsp_count",    32'(got.size()), 32'd6);
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            check_val($sformatf("bp.order%0d", k), got[k], pat(64 + k));
        end

        // Streaming: 16 reads at full rate
        idx = 0; nreq = 16; base_word = 72; cyc = 0;
        got.delete(); got_cyc.delete();
        drive_req();
        repeat (16) cycle();
        check_val("st.accepts", 32'(idx), 32'd16);
        for (int g = 0; g < 10 && got.size() < 16; g++) cycle();
        check_val("st.rsp_count", 32'(got.size()), 32'd16);
        for (int k = 0; k < 16 && k < got.size(); k++) begin
            check_val($sformatf("st.cyc%0d", k), 32'(got_cyc[k]), 32'(3 + k));
            check_val($sformatf("st.dat%0d", k), got[k], pat(72 + k));
        end

        // Reset with two requests in flight
        idx = 0; nreq = 2; base_word = 88; cyc = 0;
        got.delete(); got_cyc.delete();
        drive_req();
        cycle();
        cycle();
        check_val("mr.accepts", 32'(idx), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check_val("mr.ready", 32'(Req_Ready), 32'd0);
        check_val("mr.rv",    32'(Rsp_Valid), 32'd0);
        check_val("mr.rwr",   32'(Rsp_Wr), 32'd0);
        check_val("mr.rerr",  32'(Rsp_Err), 32'd0);
        check_val("mr.rdat",  Rsp_Data, 32'h0);
        check_val("mr.en",    32'(BRAM_EN), 32'd0);
        check_val("mr.wen",   32'(BRAM_WEN), 32'd0);
        check_val("mr.addr",  BRAM_Addr, 32'h0);
        check_val("mr.dout",  BRAM_Dout, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        repeat (5) cycle();
        check_val("mr.no_stale", 32'(got.size()), 32'd0);
        check_val("mr.occ",      32'(dut.occ_q), 32'd0);
        check_val("mr.ready_up", 32'(last_rdy), 32'd1);
        single("rd_after", 1'b0, 32'h118, 32'h0, 4'b0000, 1'b1, 4'b0000, pat(70), 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_port_initiator.md
# bram_port_initiator

Initiator-side controller for one 32-bit port of the MicroBlaze local-memory BRAM block. It accepts word read/write requests on a valid/ready request channel and drives the BRAM port signals (EN, WEN, Addr, Dout). It captures BRAM_Din one cycle after issue and returns every request's result on a valid/ready response channel through a buffered, backpressure-safe pipeline. It sits between a bus bridge or DMA engine and port B of the BRAM block.

## Interface
Parameters:
- C_MEMSIZE, 'h4000, BRAM size in bytes; legal addresses are 0 to C_MEMSIZE-1.
- C_RSP_DEPTH, 4, response FIFO depth; must be >= 3 for full throughput.

Ports:
- BRAM_Clk  in  1  sole clock; also forwarded to the BRAM.
- BRAM_Rst_N  in  1  reset, asynchronous, active-low.
- Req_Valid  in  1  request valid.
- Req_Ready  out  1  request accepted when Req_Valid && Req_Ready at a rising edge.
- Req_Wr  in  1  1 = write, 0 = read.
- Req_Addr  in  [0:31]  byte address; bits [30:31] are ignored.
- Req_Data  in  [0:31]  write data; bit 0 is the MSB.
- Req_BE  in  [0:3]  byte enables; BE[0] selects Data[0:7].
- Rsp_Valid  out  1  response valid.
- Rsp_Ready  in  1  response consumed when Rsp_Valid && Rsp_Ready.
- Rsp_Wr  out  1  echo of Req_Wr.
- Rsp_Err  out  1  address out of range.
- Rsp_Data  out  [0:31]  read data; 0 for writes and errors.
- BRAM_Clk_O  out  1  equals BRAM_Clk.
- BRAM_Rst  out  1  equals !BRAM_Rst_N.
- BRAM_EN  out  1  port enable (registered).
- BRAM_WEN  out  [0:3]  byte write enables (registered).
- BRAM_Addr  out  [0:31]  word-aligned byte address (registered).
- BRAM_Dout  out  [0:31]  write data to the BRAM (registered).
- BRAM_Din  in  [0:31]  read data from the BRAM, valid one cycle after EN.

## Operation
- Occupancy counter O, width clog2(C_RSP_DEPTH+1), counts accepted requests whose response has not yet been handshaken.
  - O increments on request accept.
  - O decrements on response handshake.
  - Simultaneous accept and response handshake: O is unchanged.
- Req_Ready = (O < C_RSP_DEPTH). It depends on registered state only, never on Req_Valid.
- Issue stage, loaded on accept:
  - BRAM_EN = 1 if Req_Addr < C_MEMSIZE, else 0.
  - BRAM_WEN = Req_BE if Req_Wr and in range, else 4'b0000.
  - BRAM_Addr = {Req_Addr[0:29], 2'b00}.
  - BRAM_Dout = Req_Data.
  - Per-request tag {wr, err} advances with the request.
- When there is no accept, BRAM_EN and BRAM_WEN return to 0 on the next edge. BRAM_Addr and BRAM_Dout hold their values.
- Capture stage: the cycle after issue, the entry {Wr, Err, Data} is written to the response FIFO. Data = BRAM_Din for an in-range read, else 0.
- Write with BE = 0000: EN is asserted, nothing is written, and the response is Wr=1 with Data=0.
- Response FIFO: C_RSP_DEPTH entries, first-word-fall-through; Rsp_* reflect the head entry. O bounds the FIFO contents, so it cannot overflow. A push into the FIFO never stalls.
- Responses return strictly in request order.
- Reset (async assert):
  - O = 0, FIFO empty, in-flight requests discarded.
  - Outputs during and after reset: Req_Ready=0 while in reset, then 1 after release; Rsp_Valid=0; Rsp_Wr=0, Rsp_Err=0, Rsp_Data=0; BRAM_EN=0, BRAM_WEN=0, BRAM_Addr=0, BRAM_Dout=0.
  - A reset in the middle of a transaction drops that transaction; no response is ever produced for it.

## Timing
- Accept at edge E0. BRAM signals are driven in the cycle after E0, and the BRAM samples at E1.
- The FIFO captures at E2; Rsp_Valid is high after E2. Latency is 2 cycles, edge to edge.
- With Rsp_Ready held at 1: one request per cycle sustained, given C_RSP_DEPTH >= 3.
- With Rsp_Ready=0: exactly C_RSP_DEPTH requests are accepted, then Req_Ready=0. After the first response handshake, Req_Ready returns to 1 in the following cycle.
- Error requests keep the same 2-cycle latency and produce no BRAM access.

## Structure
- Shared package/include holds C_BRAM_DWIDTH=32, C_BRAM_NUM_WE=4, C_BRAM_RD_LAT=1, and the response-entry field layout {wr, err, data[0:31]}.
- One sub-module: bram_rsp_fifo, a parameterised-depth FWFT FIFO of 34-bit entries with async active-low reset.
- The top level contains the occupancy counter, the issue registers and the capture logic.

## Test plan
- Write 0xDEADBEEF to 'h10 with BE=1111, then read 'h10: the bench sees EN=1, WEN=1111, Addr='h10, followed by a read response Data=0xDEADBEEF, Err=0, two cycles after accept.
- Write 0x11223344 to 'h20 with BE=1000, over prior contents 0: reading back gives 0x11000000. A write to 'h22 (misaligned) drives BRAM_Addr='h20.
- Read 'h4000: no EN pulse, and the response has Err=1, Data=0, Wr=0.
- Hold Rsp_Ready=0 and present 6 back-to-back requests: exactly 4 are accepted and Req_Ready goes to 0. Releasing Rsp_Ready drains responses in order, and the remaining 2 are then accepted.
- Stream 16 reads with Rsp_Ready=1: 16 consecutive accepts, and 16 consecutive Rsp_Valid cycles starting 2 cycles after the first accept.
- Assert BRAM_Rst_N=0 with 2 requests in flight: all outputs reach reset values immediately. After release, no stale response appears and O=0.
